// File: rtl/fpu_cmp_arbiter.sv
// fpu_cmp_arbiter
// ---------------
// Front-end controller for the shared FPU comparison unit
// (feq/fne/flt/fle/fgt/fge/fmin/fmax).
//
// Two requesters are arbitrated round-robin. The granted operands, opcode,
// tag and requester id are registered, and the comparison unit is driven
// from those registers for a single EXEC cycle. The unit's combinational
// result is captured at the end of EXEC and returned over a valid/ready
// response channel. Only one operation is in flight at a time.
//
// Optional feature macro: FPU_CMP_NV_EN
//   defined   -> resp_nv reports NaN-based invalid-operation status
//   undefined -> resp_nv is tied low and no NaN detection is built
//
// Ports
//   clk, rst_l                 clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready    request handshake, N = 0, 1
//   reqN_opcode                one-hot opcode (bit0 feq ... bit7 fmax)
//   reqN_a, reqN_b             IEEE754 operands, Std+1 bits
//   reqN_tag                   opaque tag echoed on the response
//   cmp_opcode, cmp_a, cmp_b   drive the comparison unit (non-zero only in EXEC)
//   cmp_result, cmp_minmax     comparison unit outputs
//   resp_valid / resp_ready    response handshake
//   resp_data                  compare bit (ops 0-5) or min/max value (ops 6-7)
//   resp_id, resp_tag          requester index and echoed tag
//   resp_err                   opcode was not exactly one-hot
//   resp_nv                    invalid flag (FPU_CMP_NV_EN only)

module fpu_cmp_arbiter #(
    parameter int Std   = 31,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [7:0]       req0_opcode,
    input  logic [Std:0]     req0_a,
    input  logic [Std:0]     req0_b,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [7:0]       req1_opcode,
    input  logic [Std:0]     req1_a,
    input  logic [Std:0]     req1_b,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [7:0]       cmp_opcode,
    output logic [Std:0]     cmp_a,
    output logic [Std:0]     cmp_b,
    input  logic [31:0]      cmp_result,
    input  logic [Std:0]     cmp_minmax,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [Std:0]     resp_data,
    output logic             resp_id,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic             resp_nv
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic [7:0]       op_q;
    logic [Std:0]     a_q, b_q;
    logic [TAG_W-1:0] tag_q;
    logic             id_q;
    logic             grant0, grant1;
    logic             op_legal;
    logic             nv_calc;
    logic [Std:0]     result_ext;

    // On a tie the requester that did not win last time gets the grant.
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);

    assign op_legal   = (op_q != 8'h00) && ((op_q & (op_q - 8'h01)) == 8'h00);
    assign result_ext = (Std+1)'(cmp_result);

    // The id and tag registers only change at a request handshake, so they
    // already stay stable for the whole RESP phase.
    assign resp_id  = id_q;
    assign resp_tag = tag_q;

`ifdef FPU_CMP_NV_EN
    // Exponent width follows the IEEE754 format implied by the operand width.
    localparam int EXP_W = (Std == 63) ? 11 : ((Std == 15) ? 5 : 8);
    localparam int MAN_W = Std - EXP_W;

    logic a_nan, b_nan, a_snan, b_snan;

    assign a_nan  = (&a_q[Std-1 -: EXP_W]) & (|a_q[MAN_W-1:0]);
    assign b_nan  = (&b_q[Std-1 -: EXP_W]) & (|b_q[MAN_W-1:0]);
    assign a_snan = a_nan & ~a_q[MAN_W-1];
    assign b_snan = b_nan & ~b_q[MAN_W-1];

    // Ordered comparisons signal on any NaN; equality and min/max only on sNaN.
    assign nv_calc = (|op_q[5:2]) ? (a_nan | b_nan) : (a_snan | b_snan);
`else
    assign nv_calc = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus handshake and comparison-unit outputs. Ready is gated
    // by rst_l so it reads low while reset is asserted.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        cmp_opcode = 8'h00;
        cmp_a      = '0;
        cmp_b      = '0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0 & rst_l;
                req1_ready = grant1 & rst_l;
                if (grant0 | grant1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                cmp_opcode = op_legal ? op_q : 8'h00;
                cmp_a      = a_q;
                cmp_b      = b_q;
                state_nxt  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture; inputs are sampled only at the accepting edge.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            last_grant <= 1'b1;
            op_q       <= 8'h00;
            a_q        <= '0;
            b_q        <= '0;
            tag_q      <= '0;
            id_q       <= 1'b0;
        end else if (state == IDLE && (grant0 | grant1)) begin
            last_grant <= grant1;
            id_q       <= grant1;
            if (grant0) begin
                op_q  <= req0_opcode;
                a_q   <= req0_a;
                b_q   <= req0_b;
                tag_q <= req0_tag;
            end else begin
                op_q  <= req1_opcode;
                a_q   <= req1_a;
                b_q   <= req1_b;
                tag_q <= req1_tag;
            end
        end
    end

    // Result capture at the end of EXEC; held through RESP.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            resp_data <= '0;
            resp_err  <= 1'b0;
            resp_nv   <= 1'b0;
        end else if (state == EXEC) begin
            if (!op_legal) begin
                resp_data <= '0;
            end else if (|op_q[7:6]) begin
                resp_data <= cmp_minmax;
            end else begin
                resp_data <= result_ext;
            end
            resp_err <= ~op_legal;
            resp_nv  <= op_legal & nv_calc;
        end
    end

endmodule

// File: tb/tb_fpu_cmp_arbiter.sv
// tb_fpu_cmp_arbiter
// ------------------
// Directed bench for fpu_cmp_arbiter. A small behavioural comparison unit
// answers the DUT's cmp_* outputs. Inputs change 1 time unit after a rising
// edge; outputs are sampled on the falling edge.

module tb_fpu_cmp_arbiter;

    logic        clk;
    logic        rst_l;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_opcode, req1_opcode;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_tag, req1_tag;
    logic [7:0]  cmp_opcode;
    logic [31:0] cmp_a, cmp_b;
    logic [31:0] cmp_result;
    logic [31:0] cmp_minmax;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_id;
    logic [3:0]  resp_tag;
    logic        resp_err;
    logic        resp_nv;

    int check_count = 0;
    int pass_count  = 0;

    fpu_cmp_arbiter #(.Std(31), .TAG_W(4)) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_opcode (req0_opcode),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_tag    (req0_tag),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_opcode (req1_opcode),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_tag    (req1_tag),
        .cmp_opcode  (cmp_opcode),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_result  (cmp_result),
        .cmp_minmax  (cmp_minmax),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_id     (resp_id),
        .resp_tag    (resp_tag),
        .resp_err    (resp_err),
        .resp_nv     (resp_nv)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Total-order key for non-NaN floats so ordering is an unsigned compare.
    function automatic logic [31:0] ord_key(input logic [31:0] v);
        return v[31] ? ~v : (v | 32'h8000_0000);
    endfunction

    // Behavioural comparison unit. A non one-hot opcode produces deliberate
    // garbage so the DUT's zeroing of illegal results is visible.
    logic [31:0] key_a, key_b;
    logic        any_nan;
    always_comb begin
        key_a   = ord_key(cmp_a);
        key_b   = ord_key(cmp_b);
        any_nan = ((cmp_a[30:23] == 8'hFF) && (cmp_a[22:0] != 0)) ||
                  ((cmp_b[30:23] == 8'hFF) && (cmp_b[22:0] != 0));
        cmp_result = 32'h0;
        cmp_minmax = 32'h0;
        case (cmp_opcode)
            8'h01: cmp_result = {31'h0, !any_nan && (cmp_a == cmp_b)};
            8'h02: cmp_result = {31'h0, any_nan || (cmp_a != cmp_b)};
            8'h04: cmp_result = {31'h0, !any_nan && (key_a <  key_b)};
            8'h08: cmp_result = {31'h0, !any_nan && (key_a <= key_b)};
            8'h10: cmp_result = {31'h0, !any_nan && (key_a >  key_b)};
            8'h20: cmp_result = {31'h0, !any_nan && (key_a >= key_b)};
            8'h40: cmp_minmax = (key_a < key_b) ? cmp_a : cmp_b;
            8'h80: cmp_minmax = (key_a > key_b) ? cmp_a : cmp_b;
            default: begin
                cmp_result = 32'h1;
                cmp_minmax = 32'hDEAD_BEEF;
            end
        endcase
    end

    // Pulse resp_ready for one edge; call from a falling edge, returns at P.
    task automatic complete_resp();
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_l       = 1'b0;
        req0_valid  = 1'b1;
        req1_valid  = 1'b1;
        req0_opcode = 8'h01; req0_a = 32'h0; req0_b = 32'h0; req0_tag = 4'h0;
        req1_opcode = 8'h01; req1_a = 32'h0; req1_b = 32'h0; req1_tag = 4'h0;
        resp_ready  = 1'b0;
        #1;
        check_count++;
        if ({req0_ready, req1_ready, resp_valid} !== 3'b000) begin
            $display("[TB] FAIL reset_ready: got r0=%b r1=%b rv=%b expected 0 0 0",
                     req0_ready, req1_ready, resp_valid);
        end else pass_count++;
        check_count++;
        if ({cmp_opcode, cmp_a, cmp_b} !== 72'h0) begin
            $display("[TB] FAIL reset_cmp: got op=%h a=%h b=%h expected 0",
                     cmp_opcode, cmp_a, cmp_b);
        end else pass_count++;
        check_count++;
        if ({resp_data, resp_id, resp_tag, resp_err, resp_nv} !== 39'h0) begin
            $display("[TB] FAIL reset_resp: got d=%h id=%b tag=%h err=%b nv=%b expected 0",
                     resp_data, resp_id, resp_tag, resp_err, resp_nv);
        end else pass_count++;
        @(posedge clk);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_tie();
        req0_valid = 1'b1; req0_opcode = 8'h01; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000; req0_tag = 4'h1;
        req1_valid = 1'b1; req1_opcode = 8'h80; req1_a = 32'hBFC0_0000; req1_b = 32'h3F00_0000; req1_tag = 4'h2;
        @(negedge clk);
        check_count++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("[TB] FAIL tie_first_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end else pass_count++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check_count++;
        if (cmp_opcode !== 8'h01 || req1_ready !== 1'b0) begin
            $display("[TB] FAIL tie_exec: got op=%h r1=%b expected 01 0", cmp_opcode, req1_ready);
        end else pass_count++;
        @(negedge clk);
        check_count++;
        if ({resp_valid, resp_data, resp_id, resp_tag, resp_err} !== {1'b1, 32'h1, 1'b0, 4'h1, 1'b0}) begin
            $display("[TB] FAIL tie_resp0: got v=%b d=%h id=%b tag=%h err=%b expected 1 00000001 0 1 0",
                     resp_valid, resp_data, resp_id, resp_tag, resp_err);
        end else pass_count++;
        complete_resp();
        @(negedge clk);
        check_count++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            $display("[TB] FAIL tie_second_grant: got r0=%b r1=%b expected 0 1", req0_ready, req1_ready);
        end else pass_count++;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_count++;
        if ({resp_valid, resp_data, resp_id, resp_tag, resp_err} !== {1'b1, 32'h3F00_0000, 1'b1, 4'h2, 1'b0}) begin
            $display("[TB] FAIL tie_resp1: got v=%b d=%h id=%b tag=%h err=%b expected 1 3f000000 1 2 0",
                     resp_valid, resp_data, resp_id, resp_tag, resp_err);
        end else pass_count++;
        complete_resp();
    endtask

    // Basic flt, latency, response hold, then the illegal opcode from req1
    // which has been waiting during the hold.
    task automatic test_basic_hold_illegal();
        bit ok = 0;
        req0_valid = 1'b1; req0_opcode = 8'h04; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_tag = 4'h3;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (req0_ready) ok = 1;
        end
        check_count++;
        if (!ok) $display("[TB] FAIL basic_accept: got ready=0 expected 1 within 10 cycles");
        else pass_count++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check_count++;
        if ({resp_valid, cmp_opcode, cmp_a, cmp_b} !== {1'b0, 8'h04, 32'h3F80_0000, 32'h4000_0000}) begin
            $display("[TB] FAIL basic_exec: got v=%b op=%h a=%h b=%h expected 0 04 3f800000 40000000",
                     resp_valid, cmp_opcode, cmp_a, cmp_b);
        end else pass_count++;
        req1_valid = 1'b1; req1_opcode = 8'h05; req1_a = 32'h3F80_0000; req1_b = 32'h4000_0000; req1_tag = 4'h9;
        req0_valid = 1'b1; req0_opcode = 8'h08; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000; req0_tag = 4'h5;
        @(negedge clk);
        check_count++;
        if ({resp_valid, resp_data, resp_id, resp_tag, resp_err} !== {1'b1, 32'h1, 1'b0, 4'h3, 1'b0}) begin
            $display("[TB] FAIL basic_resp: got v=%b d=%h id=%b tag=%h err=%b expected 1 00000001 0 3 0",
                     resp_valid, resp_data, resp_id, resp_tag, resp_err);
        end else pass_count++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_count++;
            if ({resp_valid, resp_data, resp_id, resp_tag, resp_err, req0_ready, req1_ready} !==
                {1'b1, 32'h1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0}) begin
                $display("[TB] FAIL hold_%0d: got v=%b d=%h id=%b tag=%h err=%b r0=%b r1=%b expected 1 00000001 0 3 0 0 0",
                         i, resp_valid, resp_data, resp_id, resp_tag, resp_err, req0_ready, req1_ready);
            end else pass_count++;
        end
        complete_resp();
        @(negedge clk);
        check_count++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            $display("[TB] FAIL hold_release_grant: got r0=%b r1=%b expected 0 1", req0_ready, req1_ready);
        end else pass_count++;
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(negedge clk);
        check_count++;
        if (cmp_opcode !== 8'h00 || req0_ready !== 1'b0) begin
            $display("[TB] FAIL illegal_exec: got op=%h r0=%b expected 00 0", cmp_opcode, req0_ready);
        end else pass_count++;
        @(negedge clk);
        check_count++;
        if ({resp_valid, resp_data, resp_id, resp_tag, resp_err, resp_nv, cmp_opcode} !==
            {1'b1, 32'h0, 1'b1, 4'h9, 1'b1, 1'b0, 8'h00}) begin
            $display("[TB] FAIL illegal_resp: got v=%b d=%h id=%b tag=%h err=%b nv=%b op=%h expected 1 0 1 9 1 0 00",
                     resp_valid, resp_data, resp_id, resp_tag, resp_err, resp_nv, cmp_opcode);
        end else pass_count++;
        complete_resp();
    endtask

    // req0 is still pending from the previous task and is granted at once.
    task automatic test_reset_exec();
        bit seen = 0;
        @(negedge clk);
        check_count++;
        if (req0_ready !== 1'b1) $display("[TB] FAIL rst_accept: got r0=%b expected 1", req0_ready);
        else pass_count++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check_count++;
        if (cmp_opcode !== 8'h08) $display("[TB] FAIL rst_pre_exec: got op=%h expected 08", cmp_opcode);
        else pass_count++;
        rst_l = 1'b0;
        #1;
        check_count++;
        if ({cmp_opcode, cmp_a, cmp_b, resp_valid, resp_data, resp_id, resp_tag, resp_err, resp_nv, req0_ready, req1_ready} !== 115'h0) begin
            $display("[TB] FAIL rst_outputs: got op=%h a=%h b=%h v=%b d=%h id=%b tag=%h err=%b nv=%b expected all 0",
                     cmp_opcode, cmp_a, cmp_b, resp_valid, resp_data, resp_id, resp_tag, resp_err, resp_nv);
        end else pass_count++;
        @(posedge clk);
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        check_count++;
        if (seen) $display("[TB] FAIL rst_no_resp: got resp_valid=1 expected 0 after reset");
        else pass_count++;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_opcode = 8'h10; req0_a = 32'h4000_0000; req0_b = 32'h3F80_0000; req0_tag = 4'hA;
        req1_valid = 1'b1; req1_opcode = 8'h01; req1_a = 32'h0;         req1_b = 32'h0;         req1_tag = 4'hB;
        @(negedge clk);
        check_count++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            $display("[TB] FAIL rst_tie_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
        end else pass_count++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_count++;
        if ({resp_valid, resp_data, resp_id, resp_tag} !== {1'b1, 32'h1, 1'b0, 4'hA}) begin
            $display("[TB] FAIL rst_tie_resp: got v=%b d=%h id=%b tag=%h expected 1 00000001 0 a",
                     resp_valid, resp_data, resp_id, resp_tag);
        end else pass_count++;
        complete_resp();
    endtask

    task automatic test_nv();
        bit ok = 0;
        logic exp_nv;
`ifdef FPU_CMP_NV_EN
        exp_nv = 1'b1;
`else
        exp_nv = 1'b0;
`endif
        req0_valid = 1'b1; req0_opcode = 8'h04; req0_a = 32'h7FC0_0000; req0_b = 32'h3F80_0000; req0_tag = 4'h7;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (req0_ready) ok = 1;
        end
        check_count++;
        if (!ok) $display("[TB] FAIL nv_accept: got ready=0 expected 1 within 10 cycles");
        else pass_count++;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_count++;
        if ({resp_valid, resp_data, resp_err, resp_nv, resp_tag} !== {1'b1, 32'h0, 1'b0, exp_nv, 4'h7}) begin
            $display("[TB] FAIL nv_resp: got v=%b d=%h err=%b nv=%b tag=%h expected 1 0 0 %b 7",
                     resp_valid, resp_data, resp_err, resp_nv, resp_tag, exp_nv);
        end else pass_count++;
        complete_resp();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_basic_hold_illegal();
        test_reset_exec();
        test_nv();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
